// File: rtl/logic_op_scheduler.sv
// logic_op_scheduler
//   Shares one combinational 4-bit logical unit between two requesters.
//   Round-robin arbitration, operand/opcode latching onto the unit pins,
//   result capture after a settle time and a valid/ready response.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for a request; ready given to the granted requester
//   ISSUE | latched operands/opcode driven to the unit, settle counter runs
//   RESP  | result held on rsp_* until the consumer takes it
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   req0_* / req1_*                 requester valid/ready, operands, opcode
//   alu_a, alu_b, alu_op, alu_out   logical unit pins (alu_op=0 when not issuing)
//   rsp_valid/ready/data/id         response handshake, result and owner
//   rsp_zero, rsp_err               result is zero / opcode was not legal
//   busy                            scheduler not in IDLE
module logic_op_scheduler #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [3:0] req0_op,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [3:0] req1_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_op,
    input  logic [3:0] alu_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_data,
    output logic       rsp_id,
    output logic       rsp_zero,
    output logic       rsp_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    state_t     state;
    logic       last_grant;
    logic       id_q;
    logic [3:0] cnt;
    logic       grant0;
    logic       grant1;
    logic       accept;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            4'b1000, 4'b1010, 4'b1001, 4'b1011,
            4'b1100, 4'b1101, 4'b1111, 4'b1110: op_legal = 1'b1;
            default:                            op_legal = 1'b0;
        endcase
    endfunction

    // req0 wins unless req1 is also pending and req0 had the last grant.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_grant);
        grant1 = req1_valid & ~grant0;
        accept = (state == IDLE) & (grant0 | grant1);
    end

    // Ready is gated by rst_n so every output reads 0 while reset is held.
    assign req0_ready = rst_n & (state == IDLE) & grant0;
    assign req1_ready = rst_n & (state == IDLE) & grant1;

    // alu_a/alu_b/alu_op double as the latched operand/opcode registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            id_q       <= 1'b0;
            cnt        <= 4'd0;
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            alu_op     <= 4'd0;
            rsp_valid  <= 1'b0;
            rsp_data   <= 4'd0;
            rsp_id     <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        id_q       <= grant1;
                        last_grant <= grant1;
                        alu_a      <= grant1 ? req1_a  : req0_a;
                        alu_b      <= grant1 ? req1_b  : req0_b;
                        alu_op     <= grant1 ? req1_op : req0_op;
                        cnt        <= SETTLE_M1;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cnt == 4'd0) begin
                        rsp_data  <= alu_out;
                        rsp_zero  <= (alu_out == 4'd0);
                        rsp_err   <= ~op_legal(alu_op);
                        rsp_id    <= id_q;
                        rsp_valid <= 1'b1;
                        alu_op    <= 4'd0;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_op_scheduler.sv
module tb_logic_op_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_a = '0, req0_b = '0, req0_op = '0;
    logic [3:0] req1_a = '0, req1_b = '0, req1_op = '0;
    logic [3:0] alu_a, alu_b, alu_op, alu_out;
    logic       rsp_valid, rsp_ready = 1'b0;
    logic [3:0] rsp_data;
    logic       rsp_id, rsp_zero, rsp_err, busy;

    // second instance built with SETTLE=3
    logic       s3_valid = 1'b0, s3_rsp_ready = 1'b0, s3_zv = 1'b0;
    logic [3:0] s3_a = '0, s3_b = '0, s3_op = '0, s3_z4 = '0;
    logic       s3_req0_ready, s3_req1_ready, s3_rsp_valid, s3_rsp_id, s3_rsp_zero, s3_rsp_err, s3_busy;
    logic [3:0] s3_alu_a, s3_alu_b, s3_alu_op, s3_alu_out, s3_rsp_data;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    // behavioural logical unit and reference rules
    function automatic logic [3:0] unit_f(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        case (op)
            4'b1000:                                     return a & b;
            4'b1010:                                     return a | b;
            4'b1001, 4'b1011, 4'b1100, 4'b1101, 4'b1111: return a ^ b;
            4'b1110:                                     return ~(a | b);
            default:                                     return 4'b0000;
        endcase
    endfunction

    function automatic logic legal_f(input logic [3:0] op);
        return op inside {4'b1000, 4'b1010, 4'b1001, 4'b1011, 4'b1100, 4'b1101, 4'b1111, 4'b1110};
    endfunction

    assign alu_out    = unit_f(alu_a, alu_b, alu_op);
    assign s3_alu_out = unit_f(s3_alu_a, s3_alu_b, s3_alu_op);

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    logic_op_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
    );

    logic_op_scheduler #(.SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(s3_valid), .req0_ready(s3_req0_ready), .req0_a(s3_a), .req0_b(s3_b), .req0_op(s3_op),
        .req1_valid(s3_zv), .req1_ready(s3_req1_ready), .req1_a(s3_z4), .req1_b(s3_z4), .req1_op(s3_z4),
        .alu_a(s3_alu_a), .alu_b(s3_alu_b), .alu_op(s3_alu_op), .alu_out(s3_alu_out),
        .rsp_valid(s3_rsp_valid), .rsp_ready(s3_rsp_ready), .rsp_data(s3_rsp_data), .rsp_id(s3_rsp_id),
        .rsp_zero(s3_rsp_zero), .rsp_err(s3_rsp_err), .busy(s3_busy)
    );

    // ---------------- reference model / monitor (default instance, SETTLE=1) ----------------
    localparam int SETTLE = 1;
    int         ncyc = 0;
    int         acc_cyc = 0;
    int         nrsp = 0;
    bit         outstanding = 0;
    bit         last_g = 1;
    bit         acc0 = 0, acc1 = 0;
    logic       cur_id;
    logic [3:0] cur_a, cur_b, cur_op, exp_d;
    logic [3:0] last_data;
    logic       last_id, last_zero, last_err;
    logic       log_id[$];
    logic [3:0] log_data[$];

    always @(negedge clk) begin
        bit exp_r0, exp_r1, exp_rv;
        ncyc++;
        acc0 = 0;
        acc1 = 0;
        if (!rst_n) begin
            outstanding = 0;
            last_g      = 1;
        end else begin
            exp_r0 = !outstanding && req0_valid && (!req1_valid || last_g);
            exp_r1 = !outstanding && req1_valid && !exp_r0;
            exp_rv = outstanding && (ncyc >= acc_cyc + SETTLE + 1);
            check("req0_ready", 8'(req0_ready), 8'(exp_r0));
            check("req1_ready", 8'(req1_ready), 8'(exp_r1));
            check("busy", 8'(busy), 8'(outstanding));
            check("rsp_valid", 8'(rsp_valid), 8'(exp_rv));
            if (outstanding && !exp_rv) begin
                check("issue_op", 8'(alu_op), 8'(cur_op));
                check("issue_ab", {alu_a, alu_b}, {cur_a, cur_b});
            end else begin
                check("alu_op_idle", 8'(alu_op), 8'd0);
            end
            if (exp_rv) begin
                exp_d = unit_f(cur_a, cur_b, cur_op);
                check("rsp_data", 8'(rsp_data), 8'(exp_d));
                check("rsp_flags", 8'({rsp_id, rsp_zero, rsp_err}),
                      8'({cur_id, exp_d == 4'd0, !legal_f(cur_op)}));
                if (rsp_ready) begin
                    outstanding = 0;
                    last_data = rsp_data; last_id = rsp_id; last_zero = rsp_zero; last_err = rsp_err;
                    log_id.push_back(rsp_id);
                    log_data.push_back(rsp_data);
                    nrsp++;
                end
            end
            if (exp_r0 || exp_r1) begin
                acc0 = exp_r0;
                acc1 = exp_r1;
                cur_id  = exp_r1;
                cur_a   = exp_r1 ? req1_a  : req0_a;
                cur_b   = exp_r1 ? req1_b  : req0_b;
                cur_op  = exp_r1 ? req1_op : req0_op;
                last_g  = exp_r1;
                acc_cyc = ncyc;
                outstanding = 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk); #4;
        rst_n = 1'b1;
    endtask

    task automatic do_op(input logic id, input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        int  n0;
        bit  got;
        @(posedge clk); #1;
        if (id) begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
        else    begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
        n0  = nrsp;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(posedge clk); #1;
            got = id ? acc1 : acc0;
        end
        check("accept_timeout", 8'(got), 8'd1);
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        for (int i = 0; i < 40 && nrsp == n0; i++) begin
            @(posedge clk); #1;
        end
        check("rsp_timeout", 8'(nrsp - n0), 8'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 8'({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zero, rsp_err, busy}), 8'd0);
        check({tag, "_ab"}, {alu_a, alu_b}, 8'd0);
        check({tag, "_opd"}, {alu_op, rsp_data}, 8'd0);
        check({tag, "_s3"}, 8'({s3_req0_ready, s3_rsp_valid, s3_busy, s3_alu_op, 1'b0}), 8'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        #12;
        check_all_zero("reset");
        @(posedge clk); #4;
        rst_n = 1'b1;

        // single AND
        rsp_ready = 1'b1;
        do_op(1'b0, 4'b1100, 4'b1010, 4'b1000);
        check("t1_data", 8'(last_data), 8'b1000);
        check("t1_flags", 8'({last_id, last_zero, last_err}), 8'b000);

        // both requesters continuously valid after reset: strict alternation
        do_reset();
        @(posedge clk); #1;
        log_id.delete(); log_data.delete();
        req0_a = 4'b0101; req0_b = 4'b0011; req0_op = 4'b1010; req0_valid = 1'b1;
        req1_a = 4'b0101; req1_b = 4'b0011; req1_op = 4'b1110; req1_valid = 1'b1;
        for (int i = 0; i < 40 && log_id.size() < 4; i++) begin
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("t2_count", 8'(log_id.size() >= 4), 8'd1);
        if (log_id.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t2_id", 8'(log_id[i]), 8'(i % 2));
                check("t2_data", 8'(log_data[i]), (i % 2) ? 8'b1000 : 8'b0111);
            end
        end
        repeat (6) @(posedge clk);

        // consumer stalls 5 cycles in RESP; the other requester waits
        #1;
        rsp_ready = 1'b0;
        req1_a = 4'b1001; req1_b = 4'b0101; req1_op = 4'b1001; req1_valid = 1'b1;
        for (int i = 0; i < 10 && !acc1; i++) begin
            @(posedge clk); #1;
        end
        req1_valid = 1'b0;
        req0_a = 4'b1111; req0_b = 4'b0001; req0_op = 4'b1000; req0_valid = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("t3_stall", 8'({rsp_valid, busy, req0_ready, req1_ready}), 8'b1100);
        check("t3_data", 8'(rsp_data), 8'b1100);
        rsp_ready = 1'b1;
        for (int i = 0; i < 10 && !acc0; i++) begin
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        repeat (4) @(posedge clk);

        // zero result and illegal opcode
        do_op(1'b1, 4'b0110, 4'b0110, 4'b1011);
        check("t4_xor", 8'({last_data, last_zero, last_err}), 8'b0000_1_0);
        do_op(1'b0, 4'b1111, 4'b1111, 4'b0111);
        check("t4_bad", 8'({last_data, last_err}), 8'b0000_1);

        // reset during ISSUE discards the transaction
        @(posedge clk); #1;
        req0_a = 4'b1010; req0_b = 4'b0110; req0_op = 4'b1100; req0_valid = 1'b1;
        for (int i = 0; i < 10 && !acc0; i++) begin
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        check("t5_in_issue", 8'(alu_op), 8'b1100);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t5_async");
        @(negedge clk);
        @(posedge clk); #4;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t5_no_rsp", 8'({rsp_valid, busy}), 8'd0);
        do_op(1'b1, 4'b0011, 4'b0101, 4'b1010);
        check("t5_req1", 8'({last_id, last_data}), 8'b1_0111);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            if (acc0 || (req0_valid && $urandom_range(31) == 0)) req0_valid = 1'b0;
            if (acc1 || (req1_valid && $urandom_range(31) == 0)) req1_valid = 1'b0;
            if (!req0_valid && $urandom_range(3) == 0) begin
                req0_a = 4'($urandom); req0_b = 4'($urandom); req0_op = 4'($urandom); req0_valid = 1'b1;
            end
            if (!req1_valid && $urandom_range(3) == 0) begin
                req1_a = 4'($urandom); req1_b = 4'($urandom); req1_op = 4'($urandom); req1_valid = 1'b1;
            end
            rsp_ready = ($urandom_range(2) != 0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("drain_idle", 8'({busy, rsp_valid}), 8'd0);

        // SETTLE=3 instance: opcode held 3 cycles, response at accept+4
        s3_rsp_ready = 1'b1;
        s3_a = 4'b0101; s3_b = 4'b0011; s3_op = 4'b1010; s3_valid = 1'b1;
        begin
            bit seen = 0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                seen = s3_req0_ready;
            end
            check("s3_accept", 8'(seen), 8'd1);
        end
        @(posedge clk); #1;
        s3_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k <= 3) begin
                check("s3_op_hold", 8'(s3_alu_op), 8'b1010);
                check("s3_rv_early", 8'(s3_rsp_valid), 8'd0);
            end else if (k == 4) begin
                check("s3_rv", 8'({s3_rsp_valid, s3_alu_op}), 8'b1_0000);
                check("s3_data", 8'({s3_rsp_data, s3_rsp_err, s3_rsp_id}), 8'b0111_0_0);
            end else begin
                check("s3_rv_done", 8'(s3_rsp_valid), 8'd0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
